// File: rtl/qu_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// qu_scheduler_pkg : shared depth/width defaults and the scheduler entry record
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package qu_scheduler_pkg;

  localparam int QU_SCHED_DEPTH     = 8;
  localparam int QU_PREG_ADDR_WIDTH = 6;
  localparam int QU_PAYLOAD_WIDTH   = 64;

  // Default-width view of one queue slot, for blocks that snoop the scheduler.
  typedef struct packed {
    logic                          valid;
    logic [QU_PAYLOAD_WIDTH-1:0]   payload;
    logic [QU_PREG_ADDR_WIDTH-1:0] rs1_tag;
    logic                          rs1_rdy;
    logic [QU_PREG_ADDR_WIDTH-1:0] rs2_tag;
    logic                          rs2_rdy;
    logic [QU_PREG_ADDR_WIDTH-1:0] rd_tag;
  } sched_entry_t;

endpackage

`default_nettype wire

// File: rtl/qu_sched_select.sv
// ---------------------------------------------------------------------------
// qu_sched_select : find-first-set over the ready vector, lowest index wins
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qu_sched_select #(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/qu_scheduler.sv
// ---------------------------------------------------------------------------
// qu_scheduler : collapsing in-order-allocate, oldest-ready-first issue queue
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qu_scheduler
  import qu_scheduler_pkg::*;
#(
  parameter  int DEPTH           = QU_SCHED_DEPTH,
  parameter  int PREG_ADDR_WIDTH = QU_PREG_ADDR_WIDTH,
  parameter  int PAYLOAD_WIDTH   = QU_PAYLOAD_WIDTH,
  localparam int CNT_W           = $clog2(DEPTH + 1),
  localparam int IDX_W           = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       schedule_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PAYLOAD_WIDTH-1:0]   in_payload,
  input  logic [PREG_ADDR_WIDTH-1:0] in_rs1_tag,
  input  logic                       in_rs1_rdy,
  input  logic [PREG_ADDR_WIDTH-1:0] in_rs2_tag,
  input  logic                       in_rs2_rdy,
  input  logic [PREG_ADDR_WIDTH-1:0] in_rd_tag,
  input  logic                       wakeup_valid,
  input  logic [PREG_ADDR_WIDTH-1:0] wakeup_tag,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [PAYLOAD_WIDTH-1:0]   issue_payload,
  output logic [PREG_ADDR_WIDTH-1:0] issue_rs1_tag,
  output logic [PREG_ADDR_WIDTH-1:0] issue_rs2_tag,
  output logic [PREG_ADDR_WIDTH-1:0] issue_rd_tag,
  output logic [CNT_W-1:0]           occupancy,
  output logic                       full,
  output logic                       empty
);

  // Same layout as sched_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic                       valid;
    logic [PAYLOAD_WIDTH-1:0]   payload;
    logic [PREG_ADDR_WIDTH-1:0] rs1_tag;
    logic                       rs1_rdy;
    logic [PREG_ADDR_WIDTH-1:0] rs2_tag;
    logic                       rs2_rdy;
    logic [PREG_ADDR_WIDTH-1:0] rd_tag;
  } entry_t;

  entry_t           entries_q [DEPTH];
  entry_t           entries_d [DEPTH];
  entry_t           entries_wk[DEPTH];
  entry_t           new_entry;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_post_issue;
  logic [DEPTH-1:0] ready_vec;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             enq_fire;
  logic             issue_fire;

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = entries_q[i].valid && entries_q[i].rs1_rdy && entries_q[i].rs2_rdy;
    end
  end

  qu_sched_select #(
    .DEPTH (DEPTH)
  ) u_select (
    .req   (ready_vec),
    .found (sel_found),
    .index (sel_idx)
  );

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign in_ready    = !full;
  assign occupancy   = count_q;
  assign enq_fire    = in_valid && in_ready;
  assign issue_valid = schedule_en && sel_found;
  assign issue_fire  = issue_valid && issue_ready;

  assign issue_payload = entries_q[sel_idx].payload;
  assign issue_rs1_tag = entries_q[sel_idx].rs1_tag;
  assign issue_rs2_tag = entries_q[sel_idx].rs2_tag;
  assign issue_rd_tag  = entries_q[sel_idx].rd_tag;

  // An incoming uop sees the same-cycle broadcast so it cannot miss its wakeup.
  always_comb begin
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.payload = in_payload;
    new_entry.rs1_tag = in_rs1_tag;
    new_entry.rs1_rdy = in_rs1_rdy || (wakeup_valid && (wakeup_tag == in_rs1_tag));
    new_entry.rs2_tag = in_rs2_tag;
    new_entry.rs2_rdy = in_rs2_rdy || (wakeup_valid && (wakeup_tag == in_rs2_tag));
    new_entry.rd_tag  = in_rd_tag;
  end

  always_comb begin
    count_post_issue = count_q - CNT_W'(issue_fire);
    count_d          = count_post_issue + CNT_W'(enq_fire);

    for (int i = 0; i < DEPTH; i++) begin
      entries_wk[i] = entries_q[i];
      if (entries_q[i].valid && wakeup_valid) begin
        if (entries_q[i].rs1_tag == wakeup_tag) entries_wk[i].rs1_rdy = 1'b1;
        if (entries_q[i].rs2_tag == wakeup_tag) entries_wk[i].rs2_rdy = 1'b1;
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_wk[i];
    end

    // Collapse: everything above the issued slot moves down one; the top slot always empties.
    if (issue_fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) entries_d[i] = entries_wk[i + 1];
      end
      entries_d[DEPTH-1] = '0;
    end

    if (enq_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == count_post_issue) entries_d[i] = new_entry;
      end
    end

    if (flush) begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

`default_nettype wire
